mem_responder: RTL
==================

Name: mem_responder

Overview:
- Fixed-latency, pipelined data-memory responder; the memory end of the CPU's load/store port.
- Replaces the single-cycle data memory so the MEM stage can be verified against a multi-cycle, in-order memory.
- Accepts one request per cycle. Returns read data, or a write acknowledge, exactly LATENCY cycles after acceptance.
- Owns the word storage array and a LATENCY-deep response shift pipeline.

Parameters:
- ADDR_W, 16: byte-address width of req_addr.
- DEPTH_LOG2, 15: log2 of storage depth in 16-bit words; storage is 2^DEPTH_LOG2 words.
- LATENCY, 4: cycles from request acceptance to response; legal range 1..8.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present this cycle.
- req_wr  input  1  1 = store, 0 = load; sampled with req_valid.
- req_addr  input  ADDR_W  byte address; bit 0 ignored (word aligned).
- req_wdata  input  16  store data; sampled with req_valid & req_wr.
- req_ready  output  1  responder can accept a request this cycle.
- resp_valid  output  1  response present this cycle (single-cycle pulse per request).
- resp_wr  output  1  response is a write acknowledge (1) or read data (0).
- resp_data  output  16  read data; 16'h0000 when resp_valid=0 or resp_wr=1.
- busy  output  1  at least one accepted request not yet responded.

Behaviour:
- Reset (async, rst=1):
  - Pipeline valid bits clear immediately.
  - resp_valid=0, resp_wr=0, resp_data=0, busy=0, req_ready=0 while rst is high.
  - Storage contents are not cleared; reads of never-written words return X in simulation.
- req_ready: 1 in every cycle with rst=0. There is no backpressure, and the pipeline never fills beyond LATENCY entries.
- Acceptance: a request is accepted on a rising edge where req_valid & req_ready.
- Indexing: index = req_addr[DEPTH_LOG2:1]; upper address bits beyond DEPTH_LOG2+1 are ignored (aliasing wraps).
- Store:
  - mem[index] <= req_wdata on the acceptance edge.
  - Pipeline entry carries wr=1 and data=0.
- Load:
  - mem[index] is read on the acceptance edge (registered read).
  - The value travels down the pipeline with wr=0.
- Ordering:
  - Strictly in order.
  - A load accepted on the edge after a store to the same word returns the new data.
  - Same-edge store/load collisions are impossible (one request per cycle).
- Latency:
  - Stage 0 is loaded on the acceptance edge; each edge advances one stage.
  - A request accepted at edge N drives resp_valid/resp_wr/resp_data during the cycle after edge N+LATENCY-1 (i.e. visible LATENCY edges counting the acceptance edge).
  - LATENCY=1: response visible the cycle immediately after acceptance.
- Back-to-back requests: consecutive accepted requests give consecutive response cycles with no bubbles. Idle request cycles propagate as resp_valid=0 bubbles.
- busy = OR of all pipeline valid bits; it is a combinational function of registered state only.
- Reset mid-operation: all in-flight responses are dropped and never emitted. Stores already accepted remain in storage.
- Output mux: resp_data is forced to 0 unless resp_valid & ~resp_wr. No X escapes on idle cycles.
- Illegal parameter (LATENCY outside 1..8): elaboration-time $error.

Test Plan:
- Store then load, LATENCY=4:
  - Stimulus: store addr 16'h0010 data 16'hBEEF, then next cycle load 16'h0010.
  - Required: write ack (resp_valid=1, resp_wr=1, resp_data=0) 4 edges after the store; read response with resp_data=16'hBEEF exactly one cycle later; busy high from the first acceptance until the cycle after the last response.
- Odd-address alias:
  - Stimulus: store 16'h0021 data 16'h1234, load 16'h0020.
  - Required: load returns 16'h1234, confirming bit 0 is ignored.
- Streaming:
  - Stimulus: 8 consecutive stores (addr 2k, data k), then 8 consecutive loads.
  - Required: 16 consecutive response cycles with no gaps; read data 0..7 in order.
- Bubbles:
  - Stimulus: load, idle, idle, load.
  - Required: responses appear with the same two-cycle gap; resp_data=0 during the gap.
- Reset mid-flight:
  - Stimulus: accept 3 loads, assert rst asynchronously between edges.
  - Required: resp_valid and busy drop immediately; no responses after rst deasserts; a previously stored word still reads back correctly.
- LATENCY=1 build:
  - Stimulus: store 16'h0002 data 16'hA5A5, then load 16'h0002.
  - Required: ack in the next cycle; read data 16'hA5A5 in the cycle after that.

Source files
------------

// File: rtl/mem_responder.sv
// Fixed-latency, in-order data-memory responder: one request per cycle, each
// answered exactly LATENCY edges after acceptance through a shift pipeline.
module mem_responder #(
  parameter int ADDR_W     = 16,
  parameter int DEPTH_LOG2 = 15,
  parameter int LATENCY    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [15:0]       req_wdata,
  output logic              req_ready,
  output logic              resp_valid,
  output logic              resp_wr,
  output logic [15:0]       resp_data,
  output logic              busy
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  generate
    if (LATENCY < 1 || LATENCY > 8) begin : g_bad_latency
      $error("mem_responder: LATENCY must be in 1..8");
    end
  endgenerate

  logic [15:0]           mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] idx;
  logic                  accept;

  logic [LATENCY-1:0]    vld_q;
  logic [LATENCY-1:0]    vld_d;
  logic [LATENCY-1:0]    wr_q;
  logic [LATENCY-1:0]    wr_d;
  logic [15:0]           data_q [LATENCY];

  // Byte bit 0 and address bits above the storage range are intentionally dropped.
  logic unused_addr;
  generate
    if (ADDR_W > DEPTH_LOG2 + 1) begin : g_addr_hi
      assign unused_addr = ^{req_addr[0], req_addr[ADDR_W-1:DEPTH_LOG2+1]};
    end else begin : g_addr_lo
      assign unused_addr = req_addr[0];
    end
  endgenerate

  assign req_ready = ~rst;
  assign accept    = req_valid & req_ready;
  assign idx       = req_addr[DEPTH_LOG2:1];

  always_comb begin
    vld_d    = '0;
    wr_d     = '0;
    vld_d[0] = accept;
    wr_d[0]  = req_wr;
    for (int i = 1; i < LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      wr_d[i]  = wr_q[i-1];
    end
  end

  // Stage 0 is loaded on the acceptance edge; valid bits are the only reset state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
    end else begin
      vld_q <= vld_d;
    end
  end

  always_ff @(posedge clk) begin
    wr_q      <= wr_d;
    data_q[0] <= req_wr ? 16'h0000 : mem_q[idx];
    for (int i = 1; i < LATENCY; i++) begin
      data_q[i] <= data_q[i-1];
    end
  end

  // Registered read: a load on the edge after a store to the same word sees the new data.
  always_ff @(posedge clk) begin
    if (accept && req_wr) begin
      mem_q[idx] <= req_wdata;
    end
  end

  assign resp_valid = vld_q[LATENCY-1];
  assign resp_wr    = vld_q[LATENCY-1] & wr_q[LATENCY-1];
  assign resp_data  = (vld_q[LATENCY-1] && !wr_q[LATENCY-1]) ? data_q[LATENCY-1] : 16'h0000;
  assign busy       = |vld_q;

endmodule
